pcs_link_controller: RTL and testbench
======================================

PCS_LINK_CONTROLLER -- requirements
Module: pcs_link_controller

Interface
REQ-001 Parameter RESTART_CYCLES, default 4: cycles the synchronizer reset is held asserted per restart.
REQ-002 Parameter LINK_TIMER, default 16: consecutive cycles of code_sync_status=1 required before link-up.
REQ-003 Parameter SYNC_TIMEOUT, default 64: cycles allowed in WAIT_SYNC before a forced restart.
REQ-004 clock  input  1  rising-edge clock of the PCS receive/transmit domain.
REQ-005 reset  input  1  reset, synchronous, active-low; clock clock.
REQ-006 code_sync_status  input  1  synchronizer lock indication.
REQ-007 rx_even  input  1  synchronizer code-group parity, 1 = even position.
REQ-008 tx_req  input  1  requester asks for the transmit datapath; level, held until granted.
REQ-009 tx_done  input  1  single-cycle pulse: requester has finished its frame.
REQ-010 sync_rst_n  output  1  active-low reset driven to the synchronizer.
REQ-011 tx_idle_en  output  1  transmitter shall emit /I/ ordered sets (K28.5 D16.2).
REQ-012 tx_grant  output  1  requester owns the transmit datapath.
REQ-013 link_up  output  1  link qualified.
REQ-014 ctrl_state  output  3  encoded current state, for debug.

Function
REQ-015 States: RESET_SYNC, WAIT_SYNC, LINK_TIMER, LINK_IDLE, GRANTED; all outputs Moore-decoded from the state register.
REQ-016 RESET_SYNC: sync_rst_n=0, tx_idle_en=1; exactly RESTART_CYCLES cycles, then WAIT_SYNC.
REQ-017 WAIT_SYNC: sync_rst_n=1, tx_idle_en=1; code_sync_status=1 -> LINK_TIMER with counter cleared; after SYNC_TIMEOUT cycles without it -> RESET_SYNC.
REQ-018 LINK_TIMER: counter increments each cycle status=1; any status=0 -> WAIT_SYNC; counter reaching LINK_TIMER-1 with status=1 -> LINK_IDLE.
REQ-019 LINK_IDLE: link_up=1, tx_idle_en=1; tx_req=1 and rx_even=1 in the same cycle -> GRANTED; tx_req with rx_even=0 waits.
REQ-020 GRANTED: link_up=1, tx_grant=1, tx_idle_en=0; tx_done -> LINK_IDLE; tx_req ignored.
REQ-021 code_sync_status=0 in LINK_IDLE or GRANTED is a sync loss -> RESET_SYNC; tx_grant and link_up drop the next cycle.
REQ-022 Sync loss and tx_done in the same cycle: loss wins.
REQ-023 tx_done outside GRANTED is ignored.
REQ-024 All counters sized ceil(log2(max parameter+1)) bits and never wrap within a state.

Reset
REQ-025 reset=0 at a rising edge shall force RESET_SYNC with restart counter 0, in any state including mid-grant.
REQ-026 Reset values: sync_rst_n=0, tx_idle_en=1, tx_grant=0, link_up=0, ctrl_state=RESET_SYNC, loss_count=0.

Configuration
REQ-027 Macro SYNC_LOSS_CNT_EN defined: output loss_count [7:0] is present and increments on each REQ-021 loss, saturating at 255.
REQ-028 Macro undefined: port and counter absent; all other behaviour identical.

Structure
REQ-029 Package pcs_ctrl_pkg holds the state encoding constants and default parameter values.
REQ-030 Sub-module pcs_link_timer: loadable up-counter with clear and terminal-count flag, used for the restart, link and timeout counts.

Verification
REQ-031 Release reset, status stays 0 -> sync_rst_n low 4 cycles, high 64 cycles, low 4 cycles again.
REQ-032 Status=1 from WAIT_SYNC entry -> link_up=1 exactly 16 cycles after status rises.
REQ-033 Status drops in LINK_TIMER cycle 10 -> back in WAIT_SYNC, link_up stays 0, timer restarts from 0 on next rise.
REQ-034 LINK_IDLE, tx_req=1 with rx_even alternating starting at 0 -> tx_grant rises after the first even cycle; tx_done -> tx_grant=0, tx_idle_en=1.
REQ-035 GRANTED, status=0 and tx_done in the same cycle -> RESET_SYNC, tx_grant=0; with SYNC_LOSS_CNT_EN, loss_count goes 0 -> 1.
REQ-036 Reset asserted in GRANTED -> all outputs at REQ-026 values after the next edge.

Source files
------------

// File: rtl/pcs_link_controller_pkg.sv
// pcs_ctrl_pkg: shared constants for the PCS link controller slice.
//   - state encoding (also exported on ctrl_state for debug)
//   - default values of the controller timing parameters
//   - counter width helper
package pcs_ctrl_pkg;

  localparam int unsigned STATE_W            = 3;
  localparam int unsigned DEF_RESTART_CYCLES = 4;
  localparam int unsigned DEF_LINK_TIMER     = 16;
  localparam int unsigned DEF_SYNC_TIMEOUT   = 64;
  localparam int unsigned LOSS_W             = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_RESET_SYNC = 3'd0,
    ST_WAIT_SYNC  = 3'd1,
    ST_LINK_TIMER = 3'd2,
    ST_LINK_IDLE  = 3'd3,
    ST_GRANTED    = 3'd4
  } state_t;

  // Bits needed to hold the largest of three parameter values.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pcs_link_controller_if.sv
// pcs_link_controller_if: transmit-datapath ownership handshake.
//   tx_req   requester -> controller, level held until granted
//   tx_done  requester -> controller, one-cycle end-of-frame pulse
//   tx_grant controller -> requester, requester owns the datapath
// master = requester side, slave = controller side.
interface pcs_link_controller_if;

  logic tx_req;
  logic tx_done;
  logic tx_grant;

  modport master (output tx_req, output tx_done, input tx_grant);
  modport slave  (input tx_req, input tx_done, output tx_grant);

endinterface

// File: rtl/pcs_link_timer.sv
// pcs_link_timer: loadable saturating up-counter with terminal-count flag.
// Ports:
//   clock, reset      clock, synchronous active-low reset
//   clear             force count to zero (highest priority after reset)
//   load, load_value  load an explicit count
//   en                count up by one, holding at all-ones
//   terminal          compare value for the flag
//   tc_c              count == terminal (combinational)
module pcs_link_timer #(
  parameter int unsigned W = 7
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         en,
  input  logic [W-1:0] terminal,
  output logic         tc_c
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] count;

  // Counter register; saturates so it never wraps inside a state.
  always_ff @(posedge clock) begin
    if (!reset)                         count <= '0;
    else if (clear)                     count <= '0;
    else if (load)                      count <= load_value;
    else if (en && (count != CNT_MAX))  count <= count + W'(1);
  end

  assign tc_c = (count == terminal);

endmodule

// File: rtl/pcs_link_controller.sv
// pcs_link_controller: PCS synchronizer restart / link qualification and
// transmit-datapath arbitration.
// Ports:
//   clock, reset          clock, synchronous active-low reset
//   code_sync_status      synchronizer lock
//   rx_even               1 = even code-group position
//   tx_bus (slave)        tx_req / tx_done in, tx_grant out
//   sync_rst_n            active-low synchronizer reset
//   tx_idle_en            transmitter sends /I/ ordered sets
//   link_up               link qualified
//   ctrl_state            current state encoding (debug)
//   loss_count            sync-loss count, saturating; only with SYNC_LOSS_CNT_EN
// Optional feature macro: SYNC_LOSS_CNT_EN.
// LINK_TIMER must be >= 2: the WAIT_SYNC cycle that sees lock counts as the
// first of the LINK_TIMER consecutive locked cycles.
module pcs_link_controller
  import pcs_ctrl_pkg::*;
#(
  parameter int unsigned RESTART_CYCLES = DEF_RESTART_CYCLES,
  parameter int unsigned LINK_TIMER     = DEF_LINK_TIMER,
  parameter int unsigned SYNC_TIMEOUT   = DEF_SYNC_TIMEOUT
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                code_sync_status,
  input  logic                rx_even,
  pcs_link_controller_if.slave tx_bus,
  output logic                sync_rst_n,
  output logic                tx_idle_en,
  output logic                link_up,
  output logic [STATE_W-1:0]  ctrl_state
`ifdef SYNC_LOSS_CNT_EN
  ,
  output logic [LOSS_W-1:0]   loss_count
`endif
);

  localparam int unsigned CNT_W = cnt_width(RESTART_CYCLES, LINK_TIMER, SYNC_TIMEOUT);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] terminal;
  logic             cnt_en;
  logic             cnt_clear;
  logic             tc;
  logic             loss;
  logic             sync_rst_n_d;
  logic             tx_idle_en_d;
  logic             tx_grant_d;
  logic             link_up_d;
  logic             tx_grant;

  // One shared timer: restart, timeout and link counts never overlap.
  pcs_link_timer #(.W(CNT_W)) u_timer (
    .clock      (clock),
    .reset      (reset),
    .clear      (cnt_clear),
    .load       (1'b0),
    .load_value ('0),
    .en         (cnt_en),
    .terminal   (terminal),
    .tc_c       (tc)
  );

  // State and output registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= ST_RESET_SYNC;
      sync_rst_n <= 1'b0;
      tx_idle_en <= 1'b1;
      tx_grant   <= 1'b0;
      link_up    <= 1'b0;
    end else begin
      state      <= next_state;
      sync_rst_n <= sync_rst_n_d;
      tx_idle_en <= tx_idle_en_d;
      tx_grant   <= tx_grant_d;
      link_up    <= link_up_d;
    end
  end

  // Next state and timer control.
  always_comb begin
    next_state = state;
    terminal   = '0;
    cnt_en     = 1'b0;
    loss       = 1'b0;
    case (state)
      ST_RESET_SYNC: begin
        terminal = CNT_W'(RESTART_CYCLES - 1);
        cnt_en   = 1'b1;
        if (tc) next_state = ST_WAIT_SYNC;
      end
      ST_WAIT_SYNC: begin
        terminal = CNT_W'(SYNC_TIMEOUT - 1);
        if (code_sync_status) begin
          next_state = ST_LINK_TIMER;
        end else begin
          cnt_en = 1'b1;
          if (tc) next_state = ST_RESET_SYNC;
        end
      end
      ST_LINK_TIMER: begin
        // Count reaching LINK_TIMER-1 on this increment qualifies the link.
        terminal = CNT_W'(LINK_TIMER - 2);
        if (!code_sync_status) begin
          next_state = ST_WAIT_SYNC;
        end else begin
          cnt_en = 1'b1;
          if (tc) next_state = ST_LINK_IDLE;
        end
      end
      ST_LINK_IDLE: begin
        if (!code_sync_status) begin
          next_state = ST_RESET_SYNC;
          loss       = 1'b1;
        end else if (tx_bus.tx_req && rx_even) begin
          next_state = ST_GRANTED;
        end
      end
      ST_GRANTED: begin
        // Sync loss takes priority over a coincident tx_done.
        if (!code_sync_status) begin
          next_state = ST_RESET_SYNC;
          loss       = 1'b1;
        end else if (tx_bus.tx_done) begin
          next_state = ST_LINK_IDLE;
        end
      end
      default: next_state = ST_RESET_SYNC;
    endcase
    cnt_clear = (next_state != state);
  end

  // Moore output decode of the upcoming state.
  always_comb begin
    sync_rst_n_d = (next_state != ST_RESET_SYNC);
    tx_idle_en_d = (next_state != ST_GRANTED);
    tx_grant_d   = (next_state == ST_GRANTED);
    link_up_d    = (next_state == ST_LINK_IDLE) || (next_state == ST_GRANTED);
  end

  assign tx_bus.tx_grant = tx_grant;
  assign ctrl_state      = state;

`ifdef SYNC_LOSS_CNT_EN
  // Sync-loss event counter, saturating at all-ones.
  always_ff @(posedge clock) begin
    if (!reset)                         loss_count <= '0;
    else if (loss && (loss_count != '1)) loss_count <= loss_count + LOSS_W'(1);
  end
`else
  logic loss_unused;
  assign loss_unused = loss;
`endif

endmodule

// File: tb/tb_pcs_link_controller.sv
// tb_pcs_link_controller: directed self-checking bench for pcs_link_controller.
// Inputs change 1 ns after each rising edge; outputs are checked there too.
module tb_pcs_link_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       code_sync_status = 1'b0;
  logic       rx_even = 1'b0;
  logic       sync_rst_n;
  logic       tx_idle_en;
  logic       link_up;
  logic [2:0] ctrl_state;
`ifdef SYNC_LOSS_CNT_EN
  logic [7:0] loss_count;
`endif

  int compared   = 0;
  int mismatched = 0;
  int n;
  logic seen_link;

  pcs_link_controller_if tx_bus ();

  pcs_link_controller dut (
    .clock            (clock),
    .reset            (reset),
    .code_sync_status (code_sync_status),
    .rx_even          (rx_even),
    .tx_bus           (tx_bus),
    .sync_rst_n       (sync_rst_n),
    .tx_idle_en       (tx_idle_en),
    .link_up          (link_up),
    .ctrl_state       (ctrl_state)
`ifdef SYNC_LOSS_CNT_EN
    ,
    .loss_count       (loss_count)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_sync_rst_n"}, 32'(sync_rst_n), 32'd0);
    check({pfx, "_tx_idle_en"}, 32'(tx_idle_en), 32'd1);
    check({pfx, "_tx_grant"},   32'(tx_bus.tx_grant), 32'd0);
    check({pfx, "_link_up"},    32'(link_up), 32'd0);
    check({pfx, "_ctrl_state"}, 32'(ctrl_state), 32'd0);
`ifdef SYNC_LOSS_CNT_EN
    check({pfx, "_loss_count"}, 32'(loss_count), 32'd0);
`endif
  endtask

  initial begin
    tx_bus.tx_req  = 1'b0;
    tx_bus.tx_done = 1'b0;

    // Reset state
    repeat (3) step();
    check_reset_values("rst");

    // Status held low: 4 low, 64 high, 4 low
    reset = 1'b1;
    seen_link = 1'b0;
    n = 0;
    while (sync_rst_n === 1'b0 && n < 200) begin n++; step(); end
    check("restart_low_1", 32'(n), 32'd4);
    n = 0;
    while (sync_rst_n === 1'b1 && n < 200) begin
      n++;
      if (link_up !== 1'b0) seen_link = 1'b1;
      step();
    end
    check("wait_sync_high", 32'(n), 32'd64);
    check("no_link_while_unsynced", 32'(seen_link), 32'd0);
    n = 0;
    while (sync_rst_n === 1'b0 && n < 200) begin n++; step(); end
    check("restart_low_2", 32'(n), 32'd4);

    // Now in the first WAIT_SYNC cycle: lock rises, link after 16 cycles
    check("in_wait_sync", 32'(ctrl_state), 32'd1);
    code_sync_status = 1'b1;
    n = 0;
    do begin step(); n++; end while (link_up !== 1'b1 && n < 100);
    check("link_up_latency", 32'(n), 32'd16);
    check("link_idle_state", 32'(ctrl_state), 32'd3);

    // Lock drops in LINK_TIMER cycle 10, timer restarts on next rise
    reset = 1'b0;
    step();
    reset = 1'b1;
    code_sync_status = 1'b0;
    n = 0;
    while (sync_rst_n !== 1'b1 && n < 50) begin n++; step(); end
    code_sync_status = 1'b1;
    repeat (10) step();
    check("lt_cycle10_state", 32'(ctrl_state), 32'd2);
    check("lt_cycle10_link", 32'(link_up), 32'd0);
    code_sync_status = 1'b0;
    step();
    check("drop_to_wait_state", 32'(ctrl_state), 32'd1);
    check("drop_to_wait_link", 32'(link_up), 32'd0);
    code_sync_status = 1'b1;
    n = 0;
    do begin step(); n++; end while (link_up !== 1'b1 && n < 100);
    check("relink_latency", 32'(n), 32'd16);

    // tx_done outside GRANTED is ignored
    tx_bus.tx_done = 1'b1;
    step();
    tx_bus.tx_done = 1'b0;
    check("done_in_idle_state", 32'(ctrl_state), 32'd3);

    // Request with rx_even alternating from 0
    tx_bus.tx_req = 1'b1;
    rx_even = 1'b0;
    step();
    check("req_odd_no_grant", 32'(tx_bus.tx_grant), 32'd0);
    rx_even = 1'b1;
    step();
    rx_even = 1'b0;
    check("req_even_grant", 32'(tx_bus.tx_grant), 32'd1);
    check("granted_idle_en", 32'(tx_idle_en), 32'd0);
    check("granted_state", 32'(ctrl_state), 32'd4);
    step();
    check("grant_holds", 32'(tx_bus.tx_grant), 32'd1);
    tx_bus.tx_done = 1'b1;
    tx_bus.tx_req  = 1'b0;
    step();
    tx_bus.tx_done = 1'b0;
    check("done_grant", 32'(tx_bus.tx_grant), 32'd0);
    check("done_idle_en", 32'(tx_idle_en), 32'd1);
    check("done_state", 32'(ctrl_state), 32'd3);

    // Sync loss and tx_done together in GRANTED: loss wins
    tx_bus.tx_req = 1'b1;
    rx_even = 1'b1;
    step();
    tx_bus.tx_req = 1'b0;
    check("regrant", 32'(tx_bus.tx_grant), 32'd1);
`ifdef SYNC_LOSS_CNT_EN
    check("loss_count_before", 32'(loss_count), 32'd0);
`endif
    code_sync_status = 1'b0;
    tx_bus.tx_done   = 1'b1;
    step();
    tx_bus.tx_done = 1'b0;
    check("loss_state", 32'(ctrl_state), 32'd0);
    check("loss_grant", 32'(tx_bus.tx_grant), 32'd0);
    check("loss_link_up", 32'(link_up), 32'd0);
    check("loss_sync_rst_n", 32'(sync_rst_n), 32'd0);
`ifdef SYNC_LOSS_CNT_EN
    check("loss_count_after", 32'(loss_count), 32'd1);
`endif

    // Reset asserted mid-grant
    code_sync_status = 1'b1;
    n = 0;
    while (link_up !== 1'b1 && n < 100) begin n++; step(); end
    check("relink_after_loss", 32'(link_up), 32'd1);
    tx_bus.tx_req = 1'b1;
    step();
    tx_bus.tx_req = 1'b0;
    check("grant_before_reset", 32'(tx_bus.tx_grant), 32'd1);
    reset = 1'b0;
    step();
    check_reset_values("midgrant_rst");
    reset = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
